pingpong_dp_ram: RTL

PINGPONG_DP_RAM -- requirements
Module: pingpong_dp_ram

---
 rtl/fft_mem_pkg.sv | 16 +
 rtl/pingpong_dp_ram_if.sv | 24 ++
 rtl/pingpong_dp_ram_bank.sv | 43 ++++
 rtl/pingpong_dp_ram.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fft_mem_pkg.sv
// Shared types for the ping-pong FFT working memory.
// Bank select, base read latency and port identifiers.
package fft_mem_pkg;

  typedef logic bank_sel_t;

  localparam int RD_LAT_BASE = 1;
  localparam int NPORT = 3;

  typedef enum logic [1:0] {
    PORT_A,
    PORT_B,
    PORT_L
  } port_id_t;

endpackage

// File: rtl/pingpong_dp_ram_if.sv
// One RAM access port: strobes, address, write data, read data.
// master drives the request, slave returns the data.
interface ppram_port_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);

  logic              re;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (
    output re, we, addr, din,
    input  dout
  );

  modport slave (
    input  re, we, addr, din,
    output dout
  );

endinterface

// File: rtl/pingpong_dp_ram_bank.sv
// ppram_bank: read-first synchronous RAM, ports work-A, work-B, load.
// Write order makes A win over B on a shared address.
module ppram_bank #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input logic         clk,
  input logic         rst,
  ppram_port_if.slave wa,
  ppram_port_if.slave wb,
  ppram_port_if.slave ld
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;
  logic [DATA_W-1:0] rl;

  always_ff @(posedge clk) begin
    if (wb.we) mem[wb.addr] <= wb.din;
    if (wa.we) mem[wa.addr] <= wa.din;
    if (ld.we) mem[ld.addr] <= ld.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
      rl <= '0;
    end else begin
      if (wa.re) ra <= mem[wa.addr];
      if (wb.re) rb <= mem[wb.addr];
      if (ld.re) rl <= mem[ld.addr];
    end
  end

  assign wa.dout = ra;
  assign wb.dout = rb;
  assign ld.dout = rl;

endmodule

// File: rtl/pingpong_dp_ram.sv
// Ping-pong RAM: A/B own the work bank, L owns the shadow bank.
// PPRAM_OUTREG_EN adds an output register (read latency 2).
module pingpong_dp_ram
  import fft_mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              vld_a,
  input  logic              re_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              vld_b,
  input  logic              re_l,
  input  logic              we_l,
  input  logic [ADDR_W-1:0] addr_l,
  input  logic [DATA_W-1:0] din_l,
  output logic [DATA_W-1:0] dout_l,
  output logic              vld_l,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              work_bank,
  output logic              collision
);

`ifdef PPRAM_OUTREG_EN
  localparam int RD_LAT = RD_LAT_BASE + 1;
`else
  localparam int RD_LAT = RD_LAT_BASE;
`endif

  bank_sel_t work_q;
  bank_sel_t work_d;
  logic      ack_q;
  logic      accept;
  logic      coll_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      work_q <= work_d;
      ack_q  <= accept;
    end
  end

  always_comb begin
    accept = swap_req & ~ack_q;
    work_d = accept ? ~work_q : work_q;
  end

  assign work_bank = work_q;
  assign swap_ack  = ack_q;

  always_ff @(posedge clk) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= we_a & we_b
                     & (addr_a == addr_b);
  end

  assign collision = coll_q;

  logic              re_v [NPORT];
  bank_sel_t         bk_v [NPORT];
  logic [DATA_W-1:0] rd   [2][NPORT];

  always_comb begin
    re_v[PORT_A] = re_a;
    re_v[PORT_B] = re_b;
    re_v[PORT_L] = re_l;
    bk_v[PORT_A] = work_q;
    bk_v[PORT_B] = work_q;
    bk_v[PORT_L] = ~work_q;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic hit;
    assign hit = (work_q == bank_sel_t'(b));

    ppram_port_if #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) wa (), wb (), ld ();

    assign wa.re   = re_a & hit;
    assign wa.we   = we_a & hit & ~rst;
    assign wa.addr = addr_a;
    assign wa.din  = din_a;
    assign wb.re   = re_b & hit;
    assign wb.we   = we_b & hit & ~rst;
    assign wb.addr = addr_b;
    assign wb.din  = din_b;
    assign ld.re   = re_l & ~hit;
    assign ld.we   = we_l & ~hit & ~rst;
    assign ld.addr = addr_l;
    assign ld.din  = din_l;

    ppram_bank #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_bank (
      .clk(clk),
      .rst(rst),
      .wa (wa),
      .wb (wb),
      .ld (ld)
    );

    assign rd[b][PORT_A] = wa.dout;
    assign rd[b][PORT_B] = wb.dout;
    assign rd[b][PORT_L] = ld.dout;
  end

  // Bank chosen at issue time steers the returning data.
  logic              v1 [NPORT];
  bank_sel_t         s1 [NPORT];
  logic [DATA_W-1:0] d1 [NPORT];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NPORT; k++) begin
      if (rst) begin
        v1[k] <= 1'b0;
        s1[k] <= '0;
      end else begin
        v1[k] <= re_v[k];
        if (re_v[k]) s1[k] <= bk_v[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NPORT; k++)
      d1[k] = rd[s1[k]][k];
  end

  logic              vq [NPORT];
  logic [DATA_W-1:0] dq [NPORT];

  if (RD_LAT > RD_LAT_BASE) begin : g_outreg
    logic              v2 [NPORT];
    logic [DATA_W-1:0] d2 [NPORT];

    always_ff @(posedge clk) begin
      for (int k = 0; k < NPORT; k++) begin
        if (rst) begin
          v2[k] <= 1'b0;
          d2[k] <= '0;
        end else begin
          v2[k] <= v1[k];
          if (v1[k]) d2[k] <= d1[k];
        end
      end
    end

    always_comb begin
      for (int k = 0; k < NPORT; k++) begin
        vq[k] = v2[k];
        dq[k] = d2[k];
      end
    end
  end else begin : g_direct
    always_comb begin
      for (int k = 0; k < NPORT; k++) begin
        vq[k] = v1[k];
        dq[k] = d1[k];
      end
    end
  end

  // A read completing into a reset cycle is squashed.
  assign vld_a  = vq[PORT_A] & ~rst;
  assign vld_b  = vq[PORT_B] & ~rst;
  assign vld_l  = vq[PORT_L] & ~rst;
  assign dout_a = dq[PORT_A];
  assign dout_b = dq[PORT_B];
  assign dout_l = dq[PORT_L];

endmodule
